// File: rtl/sub_serial_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// State encoding is fixed so the FSM can be probed consistently across the datapath family.
package sub_serial_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_SUB  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        WAIT = ST_WAIT,
        SUB  = ST_SUB,
        DONE = ST_DONE
    } state_t;

    localparam int LOAD_DELAY_MAX = 7;

endpackage

// File: rtl/sub_serial_if.sv
// Start/operand/result bundle of the bit-serial subtractor.
// The master drives the request and operands; the slave returns the difference and status.
interface sub_serial_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] out;
    logic             borrow;
    logic             done;

    modport master (output en, a, b, input  out, borrow, done);
    modport slave  (input  en, a, b, output out, borrow, done);
endinterface

// File: rtl/sub_serial_full_sub_cell.sv
// Combinational 1-bit full subtractor: d = x - y - bin, bout is the borrow out.
module full_sub_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/sub_serial.sv
// Bit-serial unsigned subtractor, LSB first, WIDTH + LOAD_DELAY cycles per operation.
// Define SUB_SERIAL_SAT_EN to floor the result at zero when the final borrow is set.
//
//   state | meaning
//   IDLE  | waiting for en; operands captured on the accepting edge
//   WAIT  | LOAD_DELAY idle cycles before the first subtract step
//   SUB   | one bit of the difference per clock
//   DONE  | result held; en acknowledges and returns to IDLE
module sub_serial
    import sub_serial_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LOAD_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst,
    sub_serial_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int DW = $clog2(LOAD_DELAY_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    // Down-counter preload: WAIT exits on the cycle the counter sits at zero.
    localparam logic [DW-1:0] DLY_INIT = DW'((LOAD_DELAY > 0) ? LOAD_DELAY - 1 : 0);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    dly_q, dly_d;
    logic             brw_q, brw_d;
    logic             done_q, done_d;
    logic             bit_d, bit_bout;

    full_sub_cell u_cell (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .bin  (brw_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        dly_d   = dly_q;
        brw_d   = brw_q;
        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    out_d   = '0;
                    cnt_d   = '0;
                    brw_d   = 1'b0;
                    dly_d   = DLY_INIT;
                    state_d = (LOAD_DELAY > 0) ? WAIT : SUB;
                end
            end
            WAIT: begin
                if (dly_q == '0) state_d = SUB;
                else             dly_d   = dly_q - 1'b1;
            end
            SUB: begin
                brw_d = bit_bout;
                out_d = {bit_d, out_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
`ifdef SUB_SERIAL_SAT_EN
                    if (bit_bout) out_d = '0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.en) state_d = IDLE;
            end
        endcase
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            dly_q   <= '0;
            brw_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            dly_q   <= dly_d;
            brw_q   <= brw_d;
            done_q  <= done_d;
        end
    end

    assign bus.out    = out_q;
    assign bus.borrow = brw_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial: default 8-bit/LOAD_DELAY=1 instance plus a 16-bit/LOAD_DELAY=0 instance.
module tb_sub_serial;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    sub_serial_if #(.WIDTH(8))  bus8 ();
    sub_serial_if #(.WIDTH(16)) bus16 ();

    sub_serial #(.WIDTH(8), .LOAD_DELAY(1)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    sub_serial #(.WIDTH(16), .LOAD_DELAY(0)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16.slave)
    );

    // Reference: plain integer subtraction reduced to w bits, or floored at 0 when saturating.
    function automatic logic [31:0] model_diff(input longint av, input longint bv, input int w);
        longint d;
        d = av - bv;
        if (d < 0) begin
`ifdef SUB_SERIAL_SAT_EN
            d = 0;
`else
            d = d + (longint'(1) << w);
`endif
        end
        return d[31:0];
    endfunction

    // Runs one full 8-bit operation including the DONE acknowledge; no checking here.
    task automatic run_op8(input logic [7:0] av, input logic [7:0] bv, output int lat,
                           output logic [7:0] res, output logic brw, output logic done_ack);
        @(negedge clk);
        bus8.a  = av;
        bus8.b  = bv;
        bus8.en = 1'b1;
        @(posedge clk); #1;
        bus8.en = 1'b0;
        bus8.a  = 8'($urandom);
        bus8.b  = 8'($urandom);
        lat = 0;
        while (bus8.done !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus8.out;
        brw = bus8.borrow;
        @(negedge clk);
        bus8.en = 1'b1;
        @(posedge clk); #1;
        bus8.en = 1'b0;
        done_ack = bus8.done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        vectors++;
        if (bus8.out !== 8'd0 || bus8.borrow !== 1'b0 || bus8.done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset8: out=%0d borrow=%b done=%b, want 0/0/0", bus8.out, bus8.borrow, bus8.done);
        end
        vectors++;
        if (bus16.out !== 16'd0 || bus16.borrow !== 1'b0 || bus16.done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset16: out=%0d borrow=%b done=%b, want 0/0/0", bus16.out, bus16.borrow, bus16.done);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus8.done !== 1'b0 || bus8.out !== 8'd0) begin
            miscompares++;
            $display("FAIL idle_hold: done=%b out=%0d with en low, want 0/0", bus8.done, bus8.out);
        end
    endtask

    task automatic test_basic();
        int lat;
        @(negedge clk);
        bus8.a = 8'd200; bus8.b = 8'd55; bus8.en = 1'b1;
        @(posedge clk); #1;
        bus8.en = 1'b0;
        lat = 0;
        while (bus8.done !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        vectors++;
        if (lat != 9) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d cycles, want 9", lat);
        end
        vectors++;
        if (bus8.out !== 8'd145 || bus8.borrow !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_result: out=%0d borrow=%b, want 145/0", bus8.out, bus8.borrow);
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus8.done !== 1'b1 || bus8.out !== 8'd145) begin
            miscompares++;
            $display("FAIL done_hold: done=%b out=%0d, want 1/145", bus8.done, bus8.out);
        end
        @(negedge clk); bus8.en = 1'b1;
        @(posedge clk); #1; bus8.en = 1'b0;
        vectors++;
        if (bus8.done !== 1'b0) begin
            miscompares++;
            $display("FAIL ack: done=%b after acknowledge, want 0", bus8.done);
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus8.done !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_no_restart: done=%b, want 0", bus8.done);
        end
    endtask

    task automatic test_edges();
        logic [7:0] ta [5] = '{8'd5, 8'd0, 8'd255, 8'd0, 8'd128};
        logic [7:0] tb [5] = '{8'd10, 8'd0, 8'd255, 8'd1, 8'd127};
        int lat;
        logic [7:0] res;
        logic brw, dack;
        for (int i = 0; i < 5; i++) begin
            run_op8(ta[i], tb[i], lat, res, brw, dack);
            vectors++;
            if (res !== model_diff(ta[i], tb[i], 8) || brw !== (ta[i] < tb[i]) || lat != 9) begin
                miscompares++;
                $display("FAIL edge_%0d: %0d-%0d out=%0d borrow=%b lat=%0d, want %0d/%b/9",
                         i, ta[i], tb[i], res, brw, lat, model_diff(ta[i], tb[i], 8), ta[i] < tb[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] av, bv, res;
        logic brw, dack;
        int lat;
        for (int i = 0; i < 24; i++) begin
            av = 8'($urandom);
            bv = 8'($urandom);
            run_op8(av, bv, lat, res, brw, dack);
            vectors++;
            if (res !== model_diff(av, bv, 8) || brw !== (av < bv) || lat != 9 || dack !== 1'b0) begin
                miscompares++;
                $display("FAIL random_%0d: %0d-%0d out=%0d borrow=%b lat=%0d ack_done=%b, want %0d/%b/9/0",
                         i, av, bv, res, brw, lat, dack, model_diff(av, bv, 8), av < bv);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        bus8.a = 8'd100; bus8.b = 8'd1; bus8.en = 1'b1;
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        bus8.a = 8'd7;
        n = 3;
        while (bus8.done !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (n != 9 || bus8.out !== 8'd99) begin
            miscompares++;
            $display("FAIL held_en_first: lat=%0d out=%0d, want 9/99", n, bus8.out);
        end
        @(posedge clk); #1;
        vectors++;
        if (bus8.done !== 1'b0) begin
            miscompares++;
            $display("FAIL held_en_ack: done=%b one edge after done, want 0", bus8.done);
        end
        n = 1;
        while (bus8.done !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (n != 11 || bus8.out !== 8'd6) begin
            miscompares++;
            $display("FAIL held_en_second: spacing=%0d out=%0d, want 11/6", n, bus8.out);
        end
        @(posedge clk); #1;
        bus8.en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (bus8.done !== 1'b0) begin
            miscompares++;
            $display("FAIL held_en_release: done=%b, want 0", bus8.done);
        end
    endtask

    task automatic test_abort_rst();
        int lat;
        logic [7:0] res;
        logic brw, dack;
        @(negedge clk);
        bus8.a = 8'd200; bus8.b = 8'd55; bus8.en = 1'b1;
        @(posedge clk); #1;
        bus8.en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus8.out !== 8'd0 || bus8.done !== 1'b0 || bus8.borrow !== 1'b0) begin
            miscompares++;
            $display("FAIL abort: out=%0d done=%b borrow=%b, want 0/0/0", bus8.out, bus8.done, bus8.borrow);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op8(8'd9, 8'd3, lat, res, brw, dack);
        vectors++;
        if (res !== 8'd6 || brw !== 1'b0 || lat != 9) begin
            miscompares++;
            $display("FAIL after_abort: out=%0d borrow=%b lat=%0d, want 6/0/9", res, brw, lat);
        end
    endtask

    task automatic test_w16();
        logic [15:0] av, bv;
        int lat;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                av = 16'd40000; bv = 16'd1234;
            end else begin
                av = 16'($urandom);
                bv = 16'($urandom);
            end
            @(negedge clk);
            bus16.a = av; bus16.b = bv; bus16.en = 1'b1;
            @(posedge clk); #1;
            bus16.en = 1'b0;
            bus16.a = 16'($urandom);
            lat = 0;
            while (bus16.done !== 1'b1 && lat < 200) begin
                @(posedge clk); #1;
                lat++;
            end
            vectors++;
            if (lat != 16 || bus16.out !== 16'(model_diff(av, bv, 16)) || bus16.borrow !== (av < bv)) begin
                miscompares++;
                $display("FAIL w16_%0d: %0d-%0d out=%0d borrow=%b lat=%0d, want %0d/%b/16",
                         i, av, bv, bus16.out, bus16.borrow, lat, model_diff(av, bv, 16), av < bv);
            end
            @(negedge clk); bus16.en = 1'b1;
            @(posedge clk); #1; bus16.en = 1'b0;
        end
    endtask

    initial begin
        bus8.en  = 1'b0; bus8.a  = '0; bus8.b  = '0;
        bus16.en = 1'b0; bus16.a = '0; bus16.b = '0;
        test_reset();
        test_basic();
        test_edges();
        test_random();
        test_back_to_back();
        test_abort_rst();
        test_w16();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
